warmboot_ctrl: RTL and testbench
================================

WARMBOOT_CTRL -- requirements
Module: warmboot_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 134217728: auto-boot countdown length in clk cycles, minimum 2*NUM_LEDS.
REQ-002 SHALL have parameter NUM_LEDS, default 8: progress-bar width, 1..32.
REQ-003 SHALL have parameter DEFAULT_IMAGE, default 1: 2-bit image index booted on timeout.
REQ-004 SHALL have parameter AUTOBOOT_EN, default 1: 1 means the countdown is armed out of reset, 0 means the block starts disarmed.
REQ-005 SHALL have parameter BOOT_SETUP, default 2: cycles s0/s1 are held stable before boot rises, minimum 1.
REQ-006 SHALL have port clk, input, 1: sole clock.
REQ-007 SHALL have port sresetn, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port activity, input, 1: single-cycle host-activity pulse (e.g. UART byte received) that cancels the countdown.
REQ-009 SHALL have port cmd_tvalid, input, 1: command byte valid.
REQ-010 SHALL have port cmd_tready, output, 1: command byte accepted.
REQ-011 SHALL have port cmd_tdata, input, 8: command byte.
REQ-012 SHALL have port leds, output, NUM_LEDS: countdown progress bar.
REQ-013 SHALL have port armed, output, 1: high while the countdown is running.
REQ-014 SHALL have port s0, output, 1: warmboot image select bit 0.
REQ-015 SHALL have port s1, output, 1: warmboot image select bit 1.
REQ-016 SHALL have port boot, output, 1: warmboot trigger.

Function
REQ-017 SHALL implement states COUNTING, IDLE, SETUP and BOOT; the counter ctr is $clog2(TIMEOUT_CYCLES+1) bits wide.
REQ-018 SHALL accept a command byte in any cycle where cmd_tvalid and cmd_tready are both high; cmd_tready is registered, high in COUNTING and IDLE, low in SETUP and BOOT.
REQ-019 SHALL decode commands as: 0x00-0x03 boot that image now; 0x10 disarm; 0x11 arm (ctr cleared to 0); all other values are accepted and ignored.
REQ-020 In COUNTING, ctr SHALL increment by 1 per cycle; when ctr == TIMEOUT_CYCLES-1 the next state is SETUP with image = DEFAULT_IMAGE.
REQ-021 In COUNTING, an activity pulse or command 0x10 SHALL move the block to IDLE with ctr frozen at its current value.
REQ-022 In IDLE, ctr SHALL hold; command 0x11 moves the block to COUNTING with ctr=0; activity and 0x10 have no effect.
REQ-023 Command 0x11 received in COUNTING SHALL clear ctr to 0 and stay in COUNTING.
REQ-024 A boot command (0x00-0x03) in COUNTING or IDLE SHALL latch image = cmd_tdata[1:0] and enter SETUP on the next cycle.
REQ-025 Simultaneous events SHALL resolve with this priority: accepted command > activity > timeout.
REQ-026 On entry to SETUP, s1/s0 SHALL take the latched image value and hold it until reset; boot stays 0 for exactly BOOT_SETUP cycles, then the state becomes BOOT.
REQ-027 In BOOT, boot SHALL be 1 and stay 1 until reset, with no further state change.
REQ-028 leds SHALL be registered (1-cycle latency from ctr): leds[i] = 1 iff ctr > (TIMEOUT_CYCLES/NUM_LEDS)*i in COUNTING or IDLE, and all ones in SETUP or BOOT.
REQ-029 armed SHALL be registered and high iff the state is COUNTING.
REQ-030 activity SHALL be ignored in SETUP and BOOT, and cmd_tdata SHALL be ignored whenever cmd_tready is low.

Reset
REQ-031 While sresetn=0, the block SHALL force: state = COUNTING if AUTOBOOT_EN else IDLE; ctr=0; leds=0; s0=s1=0; boot=0; cmd_tready=0; armed=0.
REQ-032 Reset asserted in any state, including SETUP or BOOT, SHALL abort the operation and restore the values in REQ-031 on the next clock edge.
REQ-033 In the first cycle after sresetn goes high, cmd_tready and armed SHALL take their state-derived values.

Verification (all scenarios use TIMEOUT_CYCLES=64, NUM_LEDS=8, DEFAULT_IMAGE=1, BOOT_SETUP=2)
REQ-034 Release reset with no stimulus -> leds fill one bit every 8 cycles; s1s0=01 appears 64 cycles after release; boot=1 two cycles later and holds.
REQ-035 Pulse activity at ctr=20 -> armed=0, leds frozen at 0x07, boot stays 0 for 1000 cycles; then send 0x11 -> full countdown restarts from leds=0.
REQ-036 Send 0x02 at ctr=10 -> s1s0=10 and leds=0xFF on the cycle after the handshake; boot=1 two cycles later; cmd_tready=0 from SETUP onward.
REQ-037 Send 0x03 in the same cycle as the timeout (ctr=63) -> image 3 booted, not image 1; send 0x10 together with an activity pulse -> IDLE, no boot.
REQ-038 Send 0x55 and 0x11 at ctr=30 -> 0x55 ignored; 0x11 clears ctr so boot occurs 64+2 cycles after it.
REQ-039 Assert sresetn=0 for 1 cycle during SETUP and again during BOOT -> all outputs return to REQ-031 values and the countdown reruns.

Source files
------------

// File: rtl/warmboot_ctrl.sv
// Auto-boot countdown with host override: drives the warmboot image select
// (s1/s0) and trigger (boot) pins, with an LED progress bar for the countdown.
module warmboot_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 134217728,
  parameter int unsigned NUM_LEDS       = 8,
  parameter logic [1:0]  DEFAULT_IMAGE  = 2'd1,
  parameter bit          AUTOBOOT_EN    = 1'b1,
  parameter int unsigned BOOT_SETUP     = 2
) (
  input  logic                clk,
  input  logic                sresetn,
  input  logic                activity,
  input  logic                cmd_tvalid,
  output logic                cmd_tready,
  input  logic [7:0]          cmd_tdata,
  output logic [NUM_LEDS-1:0] leds,
  output logic                armed,
  output logic                s0,
  output logic                s1,
  output logic                boot
);

  localparam int          CTR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int          SET_W = $clog2(BOOT_SETUP + 1);
  localparam int unsigned STEP  = TIMEOUT_CYCLES / NUM_LEDS;

  typedef enum logic [1:0] {COUNTING, IDLE, SETUP, BOOT} state_t;
  localparam state_t RESET_STATE = AUTOBOOT_EN ? COUNTING : IDLE;

  state_t             state, state_nxt;
  logic [CTR_W-1:0]   ctr, ctr_nxt;
  logic [SET_W-1:0]   setup_cnt, setup_nxt;
  logic [1:0]         img_nxt;
  logic [NUM_LEDS-1:0] bar;
  logic               accept, is_boot_cmd, is_disarm, is_arm;

  assign accept      = cmd_tvalid && cmd_tready;
  assign is_boot_cmd = accept && (cmd_tdata[7:2] == 6'd0);
  assign is_disarm   = accept && (cmd_tdata == 8'h10);
  assign is_arm      = accept && (cmd_tdata == 8'h11);

  always_comb begin
    bar = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++)
      bar[i] = 32'(ctr) > 32'(STEP * i);
  end

  // Priority: accepted command, then activity, then timeout. Unrecognised
  // command bytes fall through as if no command had arrived.
  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    setup_nxt = setup_cnt;
    img_nxt   = DEFAULT_IMAGE;
    case (state)
      COUNTING: begin
        if (is_boot_cmd) begin
          state_nxt = SETUP;
          img_nxt   = cmd_tdata[1:0];
          setup_nxt = '0;
        end else if (is_disarm) begin
          state_nxt = IDLE;
        end else if (is_arm) begin
          ctr_nxt = '0;
        end else if (activity) begin
          state_nxt = IDLE;
        end else begin
          ctr_nxt = ctr + CTR_W'(1);
          if (ctr == CTR_W'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = SETUP;
            setup_nxt = '0;
          end
        end
      end
      IDLE: begin
        if (is_boot_cmd) begin
          state_nxt = SETUP;
          img_nxt   = cmd_tdata[1:0];
          setup_nxt = '0;
        end else if (is_arm) begin
          state_nxt = COUNTING;
          ctr_nxt   = '0;
        end
      end
      SETUP: begin
        if (setup_cnt == SET_W'(BOOT_SETUP - 1))
          state_nxt = BOOT;
        else
          setup_nxt = setup_cnt + SET_W'(1);
      end
      default: ;
    endcase
  end

  // Status outputs follow the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state      <= RESET_STATE;
      ctr        <= '0;
      setup_cnt  <= '0;
      leds       <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      boot       <= 1'b0;
      cmd_tready <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_nxt;
      ctr        <= ctr_nxt;
      setup_cnt  <= setup_nxt;
      armed      <= (state_nxt == COUNTING);
      cmd_tready <= (state_nxt == COUNTING) || (state_nxt == IDLE);
      boot       <= (state_nxt == BOOT);
      leds       <= ((state_nxt == SETUP) || (state_nxt == BOOT)) ? '1 : bar;
      if ((state != SETUP) && (state != BOOT) && (state_nxt == SETUP)) begin
        s0 <= img_nxt[0];
        s1 <= img_nxt[1];
      end
    end
  end

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Scoreboard bench for warmboot_ctrl: a behavioural model queues the expected
// outputs of each cycle and a negedge monitor compares them against the DUT.
module tb_warmboot_ctrl;

  localparam int T  = 64;
  localparam int NL = 8;
  localparam int BS = 2;

  logic       clk = 1'b0;
  logic       sresetn, activity, cmd_tvalid, cmd_tready;
  logic [7:0] cmd_tdata;
  logic [NL-1:0] leds;
  logic       armed, s0, s1, boot;

  warmboot_ctrl #(
    .TIMEOUT_CYCLES(T),
    .NUM_LEDS(NL),
    .DEFAULT_IMAGE(2'd1),
    .AUTOBOOT_EN(1'b1),
    .BOOT_SETUP(BS)
  ) dut (
    .clk(clk),
    .sresetn(sresetn),
    .activity(activity),
    .cmd_tvalid(cmd_tvalid),
    .cmd_tready(cmd_tready),
    .cmd_tdata(cmd_tdata),
    .leds(leds),
    .armed(armed),
    .s0(s0),
    .s1(s1),
    .boot(boot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] leds;
    logic       armed, s0, s1, boot, tready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Model: "running" = countdown live, "selected" = an image has been chosen.
  bit         m_running, m_selected, m_tready;
  int         m_count, m_since;
  logic [1:0] m_img;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input bit rst_n, input bit act, input bit valid, input logic [7:0] data);
    exp_t e;
    int   old, n, bits;
    bit   acc;
    old = m_count;
    if (!rst_n) begin
      m_running = 1'b1; m_selected = 1'b0; m_count = 0; m_since = 0;
      m_img = 2'd0; m_tready = 1'b0;
      e.leds = 8'h00; e.armed = 1'b0; e.s0 = 1'b0; e.s1 = 1'b0;
      e.boot = 1'b0; e.tready = 1'b0;
    end else begin
      acc = valid && m_tready;
      if (!m_selected) begin
        if (acc && data < 8'd4) begin
          m_selected = 1'b1; m_img = data[1:0]; m_since = 0;
        end else if (acc && data == 8'h10) begin
          m_running = 1'b0;
        end else if (acc && data == 8'h11) begin
          m_running = 1'b1; m_count = 0;
        end else if (m_running && act) begin
          m_running = 1'b0;
        end else if (m_running) begin
          if (m_count == T - 1) begin
            m_selected = 1'b1; m_img = 2'd1; m_since = 0;
          end
          m_count++;
        end
      end else begin
        m_since++;
      end
      n = (old == 0) ? 0 : ((old - 1) / (T / NL) + 1);
      if (n > NL) n = NL;
      bits = (1 << n) - 1;
      m_tready = !m_selected;
      e.leds   = m_selected ? 8'hFF : bits[7:0];
      e.armed  = m_running && !m_selected;
      e.s0     = m_selected ? m_img[0] : 1'b0;
      e.s1     = m_selected ? m_img[1] : 1'b0;
      e.boot   = m_selected && (m_since >= BS);
      e.tready = m_tready;
    end
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit rst_n, input bit act, input bit valid, input logic [7:0] data);
    sresetn    = rst_n;
    activity   = act;
    cmd_tvalid = valid;
    cmd_tdata  = data;
    @(posedge clk);
    modelStep(rst_n, act, valid, data);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic resetFor(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic runUntilCount(input int target);
    int n = 0;
    while (!(m_running && !m_selected && m_count == target) && n < 2000) begin
      idle(1);
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("[TB] FAIL reach_ctr: got timeout, expected ctr=%0d", target);
    end
  endtask

  task automatic runUntilBooted();
    int n = 0;
    while (!(m_selected && m_since >= BS) && n < 2000) begin
      idle(1);
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("[TB] FAIL reach_boot: got timeout, expected boot");
    end
  endtask

  // Monitor: every cycle the block presents a full status word.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("leds",       32'(leds),       32'(mon_e.leds));
      checkOutput("armed",      32'(armed),      32'(mon_e.armed));
      checkOutput("s0",         32'(s0),         32'(mon_e.s0));
      checkOutput("s1",         32'(s1),         32'(mon_e.s1));
      checkOutput("boot",       32'(boot),       32'(mon_e.boot));
      checkOutput("cmd_tready", 32'(cmd_tready), 32'(mon_e.tready));
    end
  end

  initial begin
    int   sel_at, boot_at;
    bit   rnd_rst, rnd_act, rnd_valid;
    int   r;
    logic [7:0] rnd_data;

    sresetn = 1'b0; activity = 1'b0; cmd_tvalid = 1'b0; cmd_tdata = 8'h00;

    // Free-running countdown to the default image.
    resetFor(3);
    sel_at = -1; boot_at = -1;
    for (int k = 1; k <= 80; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      if (sel_at < 0 && {s1, s0} == 2'b01) sel_at = k;
      if (boot_at < 0 && boot) boot_at = k;
    end
    checkOutput("select_latency", sel_at, 64);
    checkOutput("boot_latency", boot_at, 66);

    // Activity cancels; re-arm restarts the full countdown.
    resetFor(2);
    runUntilCount(20);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    idle(1000);
    checkOutput("frozen_leds", 32'(leds), 32'h07);
    checkOutput("idle_no_boot", 32'(boot), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
    idle(80);

    // Explicit boot of image 2.
    resetFor(2);
    runUntilCount(10);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h02);
    checkOutput("cmd_boot_sel", 32'({s1, s0}), 32'h2);
    idle(5);

    // Command beats timeout in the same cycle.
    resetFor(2);
    runUntilCount(63);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h03);
    idle(5);
    checkOutput("cmd_over_timeout", 32'({s1, s0}), 32'h3);

    // Disarm with simultaneous activity.
    resetFor(2);
    runUntilCount(5);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10);
    idle(100);

    // Unknown byte ignored, then re-arm mid-count.
    resetFor(2);
    runUntilCount(30);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
    idle(70);

    // Reset pulses during SETUP and during BOOT.
    resetFor(2);
    runUntilCount(63);
    idle(1);
    resetFor(1);
    runUntilBooted();
    resetFor(1);
    idle(70);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      rnd_rst   = ($urandom_range(0, m_selected ? 25 : 700) == 0);
      rnd_act   = ($urandom_range(0, 39) == 0);
      rnd_valid = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 9);
      if (r < 4)       rnd_data = 8'(r);
      else if (r == 4) rnd_data = 8'h10;
      else if (r == 5) rnd_data = 8'h11;
      else             rnd_data = 8'($urandom_range(0, 255));
      applyStimulus(!rnd_rst, rnd_act, rnd_valid, rnd_data);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
